// File: rtl/alu_pkg.sv
// Shared ALU types: B.cond condition codes, NZCV flag struct, zero-register address.
package alu_pkg;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001, C_HS = 4'b0010, C_LO = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // All-ones; truncate to the register address width at the use site.
  localparam logic [31:0] XZR_ADDR = '1;

endpackage

// File: rtl/ex_mem_flag_stage_cond_eval.sv
// Combinational B.cond evaluator: ARM condition field against an NZCV value.
module cond_eval
  import alu_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  always_comb begin
    taken = 1'b1;
    unique case (cond)
      C_EQ: taken = flags.z;
      C_NE: taken = !flags.z;
      C_HS: taken = flags.c;
      C_LO: taken = !flags.c;
      C_MI: taken = flags.n;
      C_PL: taken = !flags.n;
      C_VS: taken = flags.v;
      C_VC: taken = !flags.v;
      C_HI: taken = flags.c & !flags.z;
      C_LS: taken = !flags.c | flags.z;
      C_GE: taken = (flags.n == flags.v);
      C_LT: taken = (flags.n != flags.v);
      C_GT: taken = !flags.z & (flags.n == flags.v);
      C_LE: taken = flags.z | (flags.n != flags.v);
      C_AL, C_NV: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register plus architectural NZCV register and B.cond evaluation.
// Define FLAG_FWD_EN to forward live EX flags into the condition check.
module ex_mem_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [WIDTH-1:0]  ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_carryOut,
  input  logic              ex_overflow,
  input  logic              ex_set_flags,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [WIDTH-1:0]  ex_store_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        cond_code,
  output logic              mem_valid,
  output logic [WIDTH-1:0]  mem_result,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [WIDTH-1:0]  mem_store_data,
  output logic [3:0]        flags_q,
  output logic              cond_taken,
  output logic              flag_hazard
);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic [WIDTH-1:0]  sd_q, sd_d;
  nzcv_t             nzcv_q, nzcv_d;
  nzcv_t             ex_nzcv, eff_nzcv;
  logic              ex_sets;

  assign ex_nzcv = '{n: ex_negative, z: ex_zero, c: ex_carryOut, v: ex_overflow};
  assign ex_sets = ex_valid & ex_set_flags & !flush;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    sd_d     = sd_q;
    nzcv_d   = nzcv_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
    end else if (!stall) begin
      valid_d = ex_valid;
      // Writes to the zero register are dropped here so MEM/WB never see them.
      rw_d    = ex_valid & ex_reg_write & (ex_rd != REG_AW'(XZR_ADDR));
      mr_d    = ex_valid & ex_mem_read;
      mw_d    = ex_valid & ex_mem_write;
      if (ex_valid) begin
        result_d = ex_result;
        rd_d     = ex_rd;
        sd_d     = ex_store_data;
      end
      if (ex_valid & ex_set_flags) nzcv_d = ex_nzcv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      sd_q     <= '0;
      nzcv_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      sd_q     <= sd_d;
      nzcv_q   <= nzcv_d;
    end
  end

`ifdef FLAG_FWD_EN
  assign eff_nzcv    = ex_sets ? ex_nzcv : nzcv_q;
  assign flag_hazard = 1'b0;
`else
  // Branch must wait a cycle for an in-flight flag setter to commit.
  assign eff_nzcv    = nzcv_q;
  assign flag_hazard = ex_sets;
`endif

  cond_eval u_cond_eval (
    .flags (eff_nzcv),
    .cond  (cond_e'(cond_code)),
    .taken (cond_taken)
  );

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = rw_q;
  assign mem_mem_read   = mr_q;
  assign mem_mem_write  = mw_q;
  assign mem_store_data = sd_q;
  assign flags_q        = nzcv_q;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: reset, flag commit, stall, flush, XZR, flag forwarding.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [63:0] ex_result;
  logic        ex_negative, ex_zero, ex_carryOut, ex_overflow;
  logic        ex_set_flags;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [63:0] ex_store_data;
  logic        stall, flush;
  logic [3:0]  cond_code;
  logic        mem_valid;
  logic [63:0] mem_result;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [63:0] mem_store_data;
  logic [3:0]  flags_q;
  logic        cond_taken, flag_hazard;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_flag_stage #(.WIDTH(64), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_carryOut(ex_carryOut),
    .ex_overflow(ex_overflow), .ex_set_flags(ex_set_flags), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall(stall), .flush(flush), .cond_code(cond_code),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data),
    .flags_q(flags_q), .cond_taken(cond_taken), .flag_hazard(flag_hazard)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags_in(input logic [3:0] f);
    {ex_negative, ex_zero, ex_carryOut, ex_overflow} = f;
  endtask

  task automatic sweep(input string tag, input logic [15:0] exp_vec);
    for (int i = 0; i < 16; i++) begin
      cond_code = 4'(i);
      #1;
      chk($sformatf("%s_cc%0d", tag, i), 64'(cond_taken), 64'(exp_vec[i]));
    end
  endtask

  initial begin
    reset_n = 1'b0; ex_valid = 0; ex_result = '0; set_flags_in(4'b0000);
    ex_set_flags = 0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_store_data = '0; stall = 0; flush = 0; cond_code = 4'b0000;
    #12;
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_result", mem_result, 64'd0);
    reset_n = 1'b1;

    // Load then asynchronous reset between edges
    ex_valid = 1; ex_result = 64'hDEAD; ex_rd = 5'd3; ex_reg_write = 1; ex_store_data = 64'h5;
    ex_set_flags = 1; set_flags_in(4'b1111);
    step();
    chk("ld_valid", 64'(mem_valid), 64'd1);
    chk("ld_result", mem_result, 64'hDEAD);
    chk("ld_rd", 64'(mem_rd), 64'd3);
    chk("ld_rw", 64'(mem_reg_write), 64'd1);
    chk("ld_sd", mem_store_data, 64'h5);
    chk("ld_flags", 64'(flags_q), 64'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(mem_valid), 64'd0);
    chk("arst_result", mem_result, 64'd0);
    chk("arst_rw", 64'(mem_reg_write), 64'd0);
    chk("arst_flags", 64'(flags_q), 64'd0);
    reset_n = 1'b1;
    ex_reg_write = 0;

    // ADDS overflow: N=1 Z=0 C=0 V=1
    ex_result = 64'h8000_0000_0000_0000; ex_set_flags = 1; set_flags_in(4'b1001);
    #1;
`ifndef FLAG_FWD_EN
    chk("adds_hazard", 64'(flag_hazard), 64'd1);
`endif
    step();
    chk("adds_flags", 64'(flags_q), 64'h9);
    chk("adds_result", mem_result, 64'h8000_0000_0000_0000);
    ex_valid = 0; ex_set_flags = 0;
    cond_code = 4'b1010; #1 chk("cc_GE", 64'(cond_taken), 64'd1);
    cond_code = 4'b1011; #1 chk("cc_LT", 64'(cond_taken), 64'd0);
    cond_code = 4'b0110; #1 chk("cc_VS", 64'(cond_taken), 64'd1);
    step();
    chk("bubble_valid", 64'(mem_valid), 64'd0);

    // Stall for 3 cycles with a Z-setter waiting in EX
    ex_valid = 1; ex_set_flags = 1; set_flags_in(4'b0100); ex_result = 64'h1234; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_flags", i), 64'(flags_q), 64'h9);
      chk($sformatf("stall%0d_valid", i), 64'(mem_valid), 64'd0);
      chk($sformatf("stall%0d_result", i), mem_result, 64'h8000_0000_0000_0000);
    end
    stall = 0;
    step();
    chk("unstall_flags", 64'(flags_q), 64'h4);
    chk("unstall_result", mem_result, 64'h1234);
    chk("unstall_valid", 64'(mem_valid), 64'd1);

    // Flush has priority over stall
    set_flags_in(4'b1111); ex_mem_write = 1; ex_result = 64'hAAAA; stall = 1; flush = 1;
    #1 chk("flush_hazard", 64'(flag_hazard), 64'd0);
    step();
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_mw", 64'(mem_mem_write), 64'd0);
    chk("flush_flags", 64'(flags_q), 64'h4);
    chk("flush_result", mem_result, 64'h1234);
    stall = 0; flush = 0; ex_mem_write = 0; ex_set_flags = 0;

    // Zero-register destination
    ex_rd = 5'd31; ex_reg_write = 1; ex_result = 64'hBEEF;
    step();
    chk("xzr_rw", 64'(mem_reg_write), 64'd0);
    chk("xzr_result", mem_result, 64'hBEEF);
    chk("xzr_valid", 64'(mem_valid), 64'd1);
    ex_rd = 5'd7;
    step();
    chk("x7_rw", 64'(mem_reg_write), 64'd1);
    ex_reg_write = 0; ex_valid = 0;
    sweep("swZ", 16'hE6A9);

    // Flags C only, then full condition sweep
    ex_valid = 1; ex_set_flags = 1; set_flags_in(4'b0010);
    step();
    ex_valid = 0; ex_set_flags = 0;
    chk("c_flags", 64'(flags_q), 64'h2);
    sweep("swC", 16'hD5A6);

    // SUBS producing Z=1 while a B.EQ looks at the flags
    ex_valid = 1; ex_set_flags = 1; set_flags_in(4'b0000);
    step();
    chk("z0_flags", 64'(flags_q), 64'h0);
    set_flags_in(4'b0100); cond_code = 4'b0000;
    #1;
`ifdef FLAG_FWD_EN
    chk("fwd_taken", 64'(cond_taken), 64'd1);
    chk("fwd_hazard", 64'(flag_hazard), 64'd0);
`else
    chk("nofwd_taken", 64'(cond_taken), 64'd0);
    chk("nofwd_hazard", 64'(flag_hazard), 64'd1);
`endif
    step();
    ex_valid = 0; ex_set_flags = 0;
    #1;
    chk("eq_next_taken", 64'(cond_taken), 64'd1);
    chk("eq_next_hazard", 64'(flag_hazard), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
- Sits directly downstream of the 64-bit ALU (add/sub/and/or/xor units with zero/overflow/carryOut/negative outputs).
- Registers the EX result and control into the EX/MEM pipeline register.
- Holds the architectural NZCV flag register and evaluates B.cond conditions against it, so flag-setting instructions (ADDS/SUBS/ANDS) feed later conditional branches.

Parameters:
- WIDTH, 64, datapath width of result and store data
- REG_AW, 5, destination register address width; address 2**REG_AW-1 is XZR

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_result  in  WIDTH  ALU output
- ex_negative  in  1  ALU negative flag
- ex_zero  in  1  ALU zero flag
- ex_carryOut  in  1  ALU carry flag
- ex_overflow  in  1  ALU overflow flag
- ex_set_flags  in  1  instruction updates NZCV
- ex_rd  in  REG_AW  destination register
- ex_reg_write  in  1  writes register file
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_store_data  in  WIDTH  store operand
- stall  in  1  hold the register; EX instruction replays
- flush  in  1  kill the EX instruction (insert bubble)
- cond_code  in  4  B.cond condition field (ARM encoding)
- mem_valid  out  1  registered valid
- mem_result  out  WIDTH  registered ALU result
- mem_rd  out  REG_AW  registered destination
- mem_reg_write  out  1  registered write enable
- mem_mem_read  out  1  registered load
- mem_mem_write  out  1  registered store
- mem_store_data  out  WIDTH  registered store operand
- flags_q  out  4  architectural {N,Z,C,V}
- cond_taken  out  1  cond_code satisfied by the effective flags
- flag_hazard  out  1  cond_taken not yet trustworthy; see Optional Feature

Behaviour:
- Reset (reset_n low, asynchronous): all mem_* outputs 0, flags_q = 4'b0000. Takes effect immediately, including mid-stall.
- Priority each rising edge: reset > flush > stall > load.
- load (ex_valid, !stall, !flush): every mem_* output takes its ex_* input after 1 cycle.
  - mem_valid = 1.
  - mem_reg_write = ex_reg_write & (ex_rd != all-ones); writes to XZR are dropped here.
  - ex_valid = 0 with no stall/flush: mem_valid and all mem_* control bits go 0; data fields are don't-care (implementation holds them).
- stall (no flush): all registers hold, including flags_q.
- flush, with or without stall: mem_valid, mem_reg_write, mem_mem_read and mem_mem_write go 0; data fields hold.
- Flag commit: flags_q <= {ex_negative, ex_zero, ex_carryOut, ex_overflow} only when ex_valid & ex_set_flags & !stall & !flush. Otherwise flags_q holds.
- Effective flags feed the cond_eval sub-module (combinational, 0-cycle). Conditions:
  - EQ 0000: Z.  NE 0001: !Z.
  - HS 0010: C.  LO 0011: !C.
  - MI 0100: N.  PL 0101: !N.
  - VS 0110: V.  VC 0111: !V.
  - HI 1000: C&!Z.  LS 1001: !C|Z.
  - GE 1010: N==V.  LT 1011: N!=V.
  - GT 1100: !Z&(N==V).  LE 1101: Z|(N!=V).
  - AL 1110 and 1111: 1.
- Back-to-back flag setters: the later one wins; no merging.
- No combinational path from stall/flush to mem_* outputs.

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined: effective flags are the live EX flags when ex_valid & ex_set_flags & !flush, else flags_q. cond_taken therefore sees a flag setter that is in EX in the same cycle. flag_hazard is tied 0.
- Undefined: effective flags = flags_q only. flag_hazard = ex_valid & ex_set_flags & !flush. The hazard unit must stall the branch one cycle while it is high.

Decomposition:
- Shared package alu_pkg:
  - cond_e enum holding the 16 condition codes
  - nzcv_t packed struct {n,z,c,v}
  - XZR_ADDR constant
- Sub-module cond_eval: inputs nzcv_t and cond_e, output taken. Purely combinational.

Test Plan:
- Reset mid-operation: load result 64'hDEAD with reg_write, assert reset_n=0 between edges -> all mem_* and flags_q are 0 immediately, before the next clk edge.
- Flag commit: ADDS of 64'h7FFF_FFFF_FFFF_FFFF+1 (ALU N=1,Z=0,C=0,V=1) with set_flags -> next cycle flags_q=4'b1001; cond_code GE -> 1, LT -> 0, VS -> 1.
- Stall: stall=1 for 3 cycles while the EX flag setter presents Z=1 -> mem_* and flags_q unchanged all 3 cycles; after stall drops, one edge later flags_q.Z=1.
- Flush with stall: flush=1 and stall=1 on an instruction with set_flags, mem_write -> mem_valid=0, mem_mem_write=0, flags_q unchanged.
- XZR: ex_rd=31, ex_reg_write=1 -> mem_reg_write=0, mem_result still captured.
- Forwarding:
  - With FLAG_FWD_EN: flags_q Z=0, EX SUBS produces Z=1, cond EQ -> cond_taken=1 in the same cycle, flag_hazard=0.
  - Without FLAG_FWD_EN: same stimulus -> cond_taken=0 and flag_hazard=1 that cycle; cond_taken=1 the next cycle.
